// File: rtl/round_normalize_stage_if.sv
// Handshake bus for round_normalize_stage.
// Input side : in_valid/in_ready plus the unrounded fields (sign, exponent,
//              mantissa with hidden bit, guard/round/sticky).
// Output side: out_valid/out_ready plus the packed IEEE-754 result and the
//              overflow/inexact flags.
// slave = the rounding stage, master = the producer/consumer around it.
interface round_normalize_stage_if #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   sign;
  logic [EXP_W-1:0]       exponent;
  logic [MAN_W:0]         mantissa;
  logic                   guard_bit;
  logic                   round_bit;
  logic                   sticky_bit;
  logic                   out_valid;
  logic                   out_ready;
  logic [EXP_W+MAN_W:0]   result;
  logic                   overflow;
  logic                   inexact;

  modport slave (
    input  in_valid, sign, exponent, mantissa, guard_bit, round_bit, sticky_bit,
    input  out_ready,
    output in_ready, out_valid, result, overflow, inexact
  );

  modport master (
    output in_valid, sign, exponent, mantissa, guard_bit, round_bit, sticky_bit,
    output out_ready,
    input  in_ready, out_valid, result, overflow, inexact
  );
endinterface

// File: rtl/round_normalize_stage.sv
// Two-stage round-to-nearest-even and post-normalization stage of the
// single-precision add/sub datapath.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - round_normalize_stage_if.slave: valid/ready input of
//           sign/exponent/mantissa/G/R/S, valid/ready output of the packed
//           {sign, exponent, fraction} result with overflow/inexact flags.
// Stage A captures the fields and the rounding decision; stage B adds the
// round increment, renormalizes and drives the registered outputs.
module round_normalize_stage #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input logic                  clk,
  input logic                  rst_n,
  round_normalize_stage_if.slave bus
);

  localparam int unsigned MW = MAN_W + 1;   // mantissa incl. hidden bit
  localparam int unsigned SW = MAN_W + 2;   // mantissa sum incl. carry-out
  localparam int unsigned XW = EXP_W + 1;   // exponent with overflow headroom
  localparam int unsigned RW = 1 + EXP_W + MAN_W;
  localparam logic [XW-1:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};

  // Stage A registers
  logic             valid_a;
  logic             sign_a;
  logic [EXP_W-1:0] exp_a;
  logic [MW-1:0]    man_a;
  logic             special_a;
  logic             round_up_a;
  logic             inexact_a;

  // Handshake: B takes A whenever the output register is free or draining.
  logic advance_b;
  logic accept_a;

  assign advance_b   = valid_a & (~bus.out_valid | bus.out_ready);
  assign bus.in_ready = ~valid_a | advance_b;
  assign accept_a    = bus.in_valid & bus.in_ready;

  // Rounding decision on the raw input fields
  logic special_in;
  logic round_up_in;
  logic inexact_in;

  always_comb begin
    special_in  = (bus.exponent == {EXP_W{1'b1}});
    round_up_in = bus.guard_bit & (bus.mantissa[0] | bus.round_bit | bus.sticky_bit) & ~special_in;
    inexact_in  = (bus.guard_bit | bus.round_bit | bus.sticky_bit) & ~special_in;
  end

  // Stage A register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_a    <= 1'b0;
      sign_a     <= 1'b0;
      exp_a      <= '0;
      man_a      <= '0;
      special_a  <= 1'b0;
      round_up_a <= 1'b0;
      inexact_a  <= 1'b0;
    end else begin
      if (accept_a) begin
        valid_a    <= 1'b1;
        sign_a     <= bus.sign;
        exp_a      <= bus.exponent;
        man_a      <= bus.mantissa;
        special_a  <= special_in;
        round_up_a <= round_up_in;
        inexact_a  <= inexact_in;
      end else if (advance_b) begin
        valid_a <= 1'b0;
      end
    end
  end

  // Increment, renormalize and pack
  logic [SW-1:0]    sum;
  logic [XW-1:0]    exp_n;
  logic [MAN_W-1:0] frac_n;
  logic             overflow_n;
  logic             inexact_n;
  logic [RW-1:0]    result_n;

  always_comb begin
    sum        = SW'(man_a) + SW'(round_up_a);
    exp_n      = XW'(exp_a);
    frac_n     = sum[MAN_W-1:0];
    overflow_n = 1'b0;
    inexact_n  = inexact_a;
    result_n   = '0;

    if (sum[SW-1]) begin
      // carry-out only from an all-ones mantissa: result is 1.0 x 2^(e+1)
      frac_n = sum[MAN_W:1];
      exp_n  = XW'(exp_a) + XW'(1);
    end else if ((exp_a == '0) && sum[MAN_W]) begin
      // subnormal rounded up into the smallest normal
      exp_n = XW'(1);
    end

    if (special_a) begin
      result_n  = {sign_a, exp_a, man_a[MAN_W-1:0]};
      inexact_n = 1'b0;
    end else if (exp_n >= EXP_ONES) begin
      result_n   = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      overflow_n = 1'b1;
      inexact_n  = 1'b1;
    end else begin
      result_n = {sign_a, exp_n[EXP_W-1:0], frac_n};
    end
  end

  // Stage B / output register; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid <= 1'b0;
      bus.result    <= '0;
      bus.overflow  <= 1'b0;
      bus.inexact   <= 1'b0;
    end else begin
      if (advance_b) begin
        bus.out_valid <= 1'b1;
        bus.result    <= result_n;
        bus.overflow  <= overflow_n;
        bus.inexact   <= inexact_n;
      end else if (bus.out_ready) begin
        bus.out_valid <= 1'b0;
      end
    end
  end

endmodule
